// File: rtl/drf_io_pkg.sv
// drf_io_ports shared definitions:
// register offsets within a port slot and the default window base.
package drf_io_pkg;

  localparam logic [1:0] REG_IN   = 2'd0;
  localparam logic [1:0] REG_OUT  = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_MASK = 2'd3;

  localparam logic [9:0] DEF_BASE_ADDR = 10'h3C0;

endpackage

// File: rtl/drf_io_channel.sv
// One I/O port: input synchroniser, edge capture, output latch,
// interrupt mask and per-port read data.
module drf_io_channel
  import drf_io_pkg::*;
#(
  parameter int PORT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PORT_W-1:0] pin_i,
  input  logic              we_i,
  input  logic [1:0]        rsel_i,
  input  logic [PORT_W-1:0] wdata_i,
  output logic [PORT_W-1:0] out_o,
  output logic [PORT_W-1:0] rdata_o,
  output logic              irq_o
);

  logic [PORT_W-1:0] sync1_q, sync2_q, prev_q;
  logic [PORT_W-1:0] out_q, out_d;
  logic [PORT_W-1:0] edge_q, edge_d;
  logic [PORT_W-1:0] mask_q, mask_d;
  logic [PORT_W-1:0] rise, clr;

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    clr    = '0;
    if (we_i) begin
      unique case (rsel_i)
        REG_OUT:  out_d  = wdata_i;
        REG_EDGE: clr    = wdata_i;
        REG_MASK: mask_d = wdata_i;
        default:  ;
      endcase
    end
    // a rise landing with a clear of the same bit keeps the flag
    edge_d = (edge_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      out_q   <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      out_q   <= out_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    rdata_o = sync2_q;
    unique case (rsel_i)
      REG_IN:   rdata_o = sync2_q;
      REG_OUT:  rdata_o = out_q;
      REG_EDGE: rdata_o = edge_q;
      REG_MASK: rdata_o = mask_q;
      default:  ;
    endcase
  end

  assign out_o = out_q;
  assign irq_o = |(edge_q & mask_q);

endmodule

// File: rtl/drf_io_ports.sv
// Memory-mapped I/O port controller: window decode, registered read
// path and interrupt aggregation over NUM_PORTS channels.
module drf_io_ports
  import drf_io_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PORT_W    = 4,
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_write_en,
  input  logic                        in_read_en,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_data_valid,
  input  logic [NUM_PORTS*PORT_W-1:0] in_port,
  output logic [NUM_PORTS*PORT_W-1:0] out_port,
  output logic                        out_irq
);

  localparam logic [ADDR_W-1:0] WIN = ADDR_W'(4 * NUM_PORTS);

  logic [ADDR_W-1:0]           off;
  logic                        in_win;
  logic [1:0]                  rsel;
  logic [NUM_PORTS-1:0]        psel, irq;
  logic [NUM_PORTS*PORT_W-1:0] rd_all;
  logic [PORT_W-1:0]           rd_mux;
  logic [DATA_W-1:0]           data_q, data_d;
  logic                        valid_q, valid_d;

  assign off    = in_addr - BASE_ADDR;
  assign in_win = (in_addr >= BASE_ADDR) && (off < WIN);
  assign rsel   = off[1:0];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
    assign psel[g] = in_win && (off[ADDR_W-1:2] == (ADDR_W-2)'(g));

    drf_io_channel #(
      .PORT_W(PORT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (in_port[g*PORT_W +: PORT_W]),
      .we_i   (in_write_en && psel[g]),
      .rsel_i (rsel),
      .wdata_i(in_data[PORT_W-1:0]),
      .out_o  (out_port[g*PORT_W +: PORT_W]),
      .rdata_o(rd_all[g*PORT_W +: PORT_W]),
      .irq_o  (irq[g])
    );
  end

  if (DATA_W > PORT_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^in_data[DATA_W-1:PORT_W];
  end

  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (psel[p]) rd_mux = rd_all[p*PORT_W +: PORT_W];
    end
    valid_d = in_read_en && in_win;
    data_d  = valid_d ? DATA_W'(rd_mux) : '0;
  end

  // sampled before any same-cycle write lands, so reads see old data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data       = data_q;
  assign out_data_valid = valid_q;
  assign out_irq        = |irq;

endmodule

// File: tb/tb_drf_io_ports.sv
// Scoreboard bench for drf_io_ports: read expectations are queued at
// issue time and checked by a monitor when out_data_valid appears.
module tb_drf_io_ports;

  localparam logic [9:0] BASE = 10'h3C0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  in_addr;
  logic [7:0]  in_data;
  logic        in_write_en;
  logic        in_read_en;
  logic [7:0]  out_data;
  logic        out_data_valid;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic        out_irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  drf_io_ports dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .in_write_en   (in_write_en),
    .in_read_en    (in_read_en),
    .out_data      (out_data),
    .out_data_valid(out_data_valid),
    .in_port       (in_port),
    .out_port      (out_port),
    .out_irq       (out_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(out_data), 32'hDEAD);
      end else begin
        chk("read_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    in_addr     = a;
    in_data     = d;
    in_write_en = 1'b1;
    step();
    in_write_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [7:0] exp);
    in_addr    = a;
    in_read_en = 1'b1;
    exp_q.push_back(exp);
    step();
    in_read_en = 1'b0;
  endtask

  task automatic rd_bad(input logic [9:0] a);
    in_addr    = a;
    in_read_en = 1'b1;
    step();
    in_read_en = 1'b0;
    chk("oow_valid", 32'(out_data_valid), 32'h0);
    chk("oow_data", 32'(out_data), 32'h0);
  endtask

  logic [15:0] snap;

  initial begin
    rst_n       = 1'b0;
    in_addr     = '0;
    in_data     = '0;
    in_write_en = 1'b0;
    in_read_en  = 1'b0;
    in_port     = 16'hFFFF;

    // reset with inputs held high
    idle(2);
    chk("rst_out_port", 32'(out_port), 32'h0);
    chk("rst_irq", 32'(out_irq), 32'h0);
    chk("rst_valid", 32'(out_data_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    idle(3);
    for (int p = 0; p < 4; p++) rd(BASE + 10'(4*p + 2), 8'h0F);
    for (int p = 0; p < 4; p++) rd(BASE + 10'(4*p + 3), 8'h00);
    chk("rst_irq_masked", 32'(out_irq), 32'h0);
    for (int p = 0; p < 4; p++) wr(BASE + 10'(4*p + 2), 8'h0F);
    in_port = 16'h0000;
    idle(3);
    for (int p = 0; p < 4; p++) rd(BASE + 10'(4*p + 2), 8'h00);

    // OUT write and readback
    wr(BASE + 10'd5, 8'hA5);
    chk("out_port_p1", 32'(out_port), 32'h0050);
    rd(BASE + 10'd5, 8'h05);
    rd(BASE + 10'd1, 8'h00);

    // edge capture, W1C racing a new rise
    in_port = 16'h0004;
    idle(3);
    rd(BASE + 10'd2, 8'h04);
    rd(BASE + 10'd0, 8'h04);
    in_port = 16'h0000;
    idle(3);
    in_port = 16'h0004;
    idle(2);
    wr(BASE + 10'd2, 8'h04);
    rd(BASE + 10'd2, 8'h04);
    wr(BASE + 10'd2, 8'h04);
    rd(BASE + 10'd2, 8'h00);

    // interrupt masking on port 2
    in_port = 16'h0304;
    idle(3);
    rd(BASE + 10'd10, 8'h03);
    chk("irq_unmasked0", 32'(out_irq), 32'h0);
    wr(BASE + 10'd11, 8'h02);
    chk("irq_set", 32'(out_irq), 32'h1);
    wr(BASE + 10'd10, 8'h02);
    chk("irq_cleared", 32'(out_irq), 32'h0);
    rd(BASE + 10'd10, 8'h01);

    // decode boundary
    snap = out_port;
    wr(BASE - 10'd1, 8'hFF);
    wr(BASE + 10'd16, 8'hFF);
    chk("oow_out_port", 32'(out_port), 32'(snap));
    chk("oow_irq", 32'(out_irq), 32'h0);
    rd_bad(BASE - 10'd1);
    rd_bad(BASE + 10'd16);
    wr(BASE + 10'd0, 8'h0F);
    rd(BASE + 10'd0, 8'h04);
    rd(BASE + 10'd5, 8'h05);
    rd(BASE + 10'd7, 8'h00);
    rd(BASE + 10'd11, 8'h02);

    // read/write collision on port 3 OUT
    wr(BASE + 10'd13, 8'h01);
    in_addr     = BASE + 10'd13;
    in_data     = 8'h09;
    in_write_en = 1'b1;
    in_read_en  = 1'b1;
    exp_q.push_back(8'h01);
    step();
    in_write_en = 1'b0;
    in_read_en  = 1'b0;
    chk("collide_out_port", 32'(out_port[15:12]), 32'h9);
    rd(BASE + 10'd13, 8'h09);

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
